arith_result_writeback: RTL and testbench

//  Consumer end of the arithmetic unit's 32-bit result bus.
//  - Accepts {result, opcode, dest reg} through a valid/ready handshake.
//  - Splits each result into 16-bit register-file writes: low half to rd.
//  - For a multiply whose high half is nonzero, also writes the high half to rd+1.
//  - Updates zero/carry status flags.
//  - Sits between the arithmetic unit output and the register-file write port.

---
 rtl/arith_pkg.sv | 25 ++
 rtl/arith_result_writeback.sv | 116 +++++++++++
 tb/tb_arith_result_writeback.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic unit and its result writeback stage.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
//
// Contents: opcode encodings, writeback FSM state encoding, and a helper
// that says whether an opcode commits a register-file write.
package arith_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_MUL   = 3'b001;
    localparam logic [2:0] OP_ADIFF = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } wb_state_t;

    // Opcodes 1xx are accepted but produce no write and leave the flags alone.
    function automatic logic op_writes(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/arith_result_writeback.sv
// Splits 2*DATA_W arithmetic results into DATA_W register-file writes and keeps zero/carry flags.
// Latency: op accepted at edge N -> low write visible after N+1, optional high write after N+2.
// Backpressure: in_ready drops only while a two-word multiply still owes its high-half write.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   in_valid/in_ready        result handshake; in_result {hi,lo}, in_opcode, in_rd
//   wr_en/wr_addr/wr_data    registered register-file write port
//   flag_zero/flag_carry     status of the last committed writing op
//   busy                     holding register occupied
module arith_result_writeback
    import arith_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*DATA_W-1:0]     in_result,
    input  logic [2:0]              in_opcode,
    input  logic [REG_ADDR_W-1:0]   in_rd,
    output logic                    wr_en,
    output logic [REG_ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]       wr_data,
    output logic                    flag_zero,
    output logic                    flag_carry,
    output logic                    busy
);

    localparam logic [REG_ADDR_W-1:0] ADDR_ONE = {{(REG_ADDR_W-1){1'b0}}, 1'b1};

    wb_state_t               state, state_nxt;
    logic [2*DATA_W-1:0]     hold_result;
    logic [2:0]              hold_opcode;
    logic [REG_ADDR_W-1:0]   hold_rd;

    logic                    need_hi;
    logic                    last_write;
    logic                    accept;
    logic                    accept_wr;
    logic                    issue_wr;
    logic [REG_ADDR_W-1:0]   issue_addr;
    logic [DATA_W-1:0]       issue_data;

    assign need_hi    = (hold_opcode == OP_MUL) && (hold_result[2*DATA_W-1:DATA_W] != '0);
    // The write issued at the coming edge finishes the held op, so its slot can be refilled.
    assign last_write = (state == HI) || ((state == LO) && !need_hi);
    assign in_ready   = !rst && ((state == IDLE) || last_write);
    assign accept     = in_valid && in_ready;
    // Non-writing opcodes are swallowed here and never enter the holding register.
    assign accept_wr  = accept && op_writes(in_opcode);
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        issue_wr   = 1'b0;
        issue_addr = hold_rd;
        issue_data = hold_result[DATA_W-1:0];
        unique case (state)
            IDLE: begin
                state_nxt = accept_wr ? LO : IDLE;
            end
            LO: begin
                issue_wr = 1'b1;
                if (need_hi) begin
                    state_nxt = HI;
                end else begin
                    state_nxt = accept_wr ? LO : IDLE;
                end
            end
            HI: begin
                issue_wr   = 1'b1;
                issue_addr = hold_rd + ADDR_ONE;  // wraps modulo register count
                issue_data = hold_result[2*DATA_W-1:DATA_W];
                state_nxt  = accept_wr ? LO : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hold_result <= '0;
            hold_opcode <= '0;
            hold_rd     <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            flag_zero   <= 1'b0;
            flag_carry  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept_wr) begin
                hold_result <= in_result;
                hold_opcode <= in_opcode;
                hold_rd     <= in_rd;
            end
            wr_en <= issue_wr;
            if (issue_wr) begin
                wr_addr <= issue_addr;
                wr_data <= issue_data;
            end
            // Flags move together with the final write of the op.
            if (last_write) begin
                flag_zero  <= (hold_result == '0);
                flag_carry <= (hold_result[2*DATA_W-1:DATA_W] != '0);
            end
        end
    end

endmodule

// File: tb/tb_arith_result_writeback.sv
// Scoreboard bench for arith_result_writeback: directed cases then randomized traffic with resets.
// Latency: expected writes queued at handshake time, popped whenever wr_en is seen.
// Backpressure: stimulus holds each op until the DUT handshakes it.
module tb_arith_result_writeback;
    import arith_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [2:0]  in_opcode;
    logic [2:0]  in_rd;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        flag_zero;
    logic        flag_carry;
    logic        busy;

    arith_result_writeback #(.DATA_W(16), .REG_ADDR_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .busy       (busy)
    );

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
        logic        z;
        logic        c;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic mz = 1'b0, mc = 1'b0;       // model flags after all queued writes
    logic vis_z = 1'b0, vis_c = 1'b0; // flags expected on the DUT pins now
    logic acc_seen = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each writing op becomes a list of (addr,data) writes;
    // a multiply with a nonzero upper half writes it to the next register.
    task automatic model_accept(input logic [2:0] op, input logic [31:0] res, input logic [2:0] rd);
        exp_t e;
        logic [15:0] lo, hi;
        lo = res[15:0];
        hi = res[31:16];
        if (op > 3'd3) return;
        if (op == OP_MUL && hi != 16'h0) begin
            e.addr = rd; e.data = lo; e.z = mz; e.c = mc;
            q.push_back(e);
            mz = (res == 32'h0); mc = 1'b1;
            e.addr = (rd + 3'd1) % 8; e.data = hi; e.z = mz; e.c = mc;
            q.push_back(e);
        end else begin
            mz = (res == 32'h0); mc = (hi != 16'h0);
            e.addr = rd; e.data = lo; e.z = mz; e.c = mc;
            q.push_back(e);
        end
    endtask

    // Monitor and handshake observer, both away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (wr_en === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_write", {29'h0, wr_addr}, 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("wr_addr", {29'h0, wr_addr}, {29'h0, e.addr});
                chk("wr_data", {16'h0, wr_data}, {16'h0, e.data});
                vis_z = e.z;
                vis_c = e.c;
            end
        end
        chk("flag_zero", {31'h0, flag_zero}, {31'h0, vis_z});
        chk("flag_carry", {31'h0, flag_carry}, {31'h0, vis_c});
        acc_seen = 1'b0;
        if (rst) begin
            q.delete();
            mz = 1'b0; mc = 1'b0;
            vis_z = 1'b0; vis_c = 1'b0;
        end else if (in_valid && in_ready) begin
            acc_seen = 1'b1;
            model_accept(in_opcode, in_result, in_rd);
        end
    end

    // Present one op and hold it until handshaken; returns 1ns after the accept edge.
    task automatic drive(input logic [2:0] op, input logic [31:0] res, input logic [2:0] rd);
        int budget;
        budget = 0;
        in_valid = 1'b1; in_opcode = op; in_result = res; in_rd = rd;
        do begin
            @(negedge clk);
            budget++;
        end while (!in_ready && budget < 50);
        if (!in_ready) chk("accept_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] res;
        int          sel;
        rst = 1'b1; in_valid = 1'b0; in_result = '0; in_opcode = '0; in_rd = '0;

        // Reset state
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_wr_en", {31'h0, wr_en}, 32'h0);
        chk("rst_wr_addr", {29'h0, wr_addr}, 32'h0);
        chk("rst_wr_data", {16'h0, wr_data}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: ADD single write
        drive(OP_ADD, 32'h0000_1234, 3'd3);
        @(negedge clk);
        chk("t1_ready_lo", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        chk("t1_wr_en", {31'h0, wr_en}, 32'h1);
        chk("t1_addr", {29'h0, wr_addr}, 32'h3);
        chk("t1_data", {16'h0, wr_data}, 32'h1234);
        chk("t1_zero", {31'h0, flag_zero}, 32'h0);
        chk("t1_carry", {31'h0, flag_carry}, 32'h0);

        // 2: MUL two writes with address wrap
        drive(OP_MUL, 32'h0002_0001, 3'd7);
        @(negedge clk);
        chk("t2_ready_lo", {31'h0, in_ready}, 32'h0);
        chk("t2_busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        chk("t2_wr_en_lo", {31'h0, wr_en}, 32'h1);
        chk("t2_addr_lo", {29'h0, wr_addr}, 32'h7);
        chk("t2_data_lo", {16'h0, wr_data}, 32'h0001);
        @(negedge clk);
        chk("t2_wr_en_hi", {31'h0, wr_en}, 32'h1);
        chk("t2_addr_hi", {29'h0, wr_addr}, 32'h0);
        chk("t2_data_hi", {16'h0, wr_data}, 32'h0002);
        chk("t2_carry", {31'h0, flag_carry}, 32'h1);

        // 3: MUL with zero result writes once
        drive(OP_MUL, 32'h0, 3'd2);
        @(negedge clk);
        chk("t3_ready_lo", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        chk("t3_addr", {29'h0, wr_addr}, 32'h2);
        chk("t3_zero", {31'h0, flag_zero}, 32'h1);
        chk("t3_carry", {31'h0, flag_carry}, 32'h0);
        @(negedge clk);
        chk("t3_single", {31'h0, wr_en}, 32'h0);

        // 4: non-writing opcode
        drive(3'b101, 32'hFFFF_FFFF, 3'd4);
        @(negedge clk);
        chk("t4_ready", {31'h0, in_ready}, 32'h1);
        chk("t4_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        chk("t4_no_wr", {31'h0, wr_en}, 32'h0);
        chk("t4_zero_kept", {31'h0, flag_zero}, 32'h1);
        @(posedge clk); #1;

        // 5: back-to-back ADDs, no bubbles
        for (int i = 0; i < 6; i++) begin
            if (i < 3) begin
                in_valid = 1'b1; in_opcode = OP_ADD;
                in_result = 32'(i + 1); in_rd = 3'(i + 1);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 3) chk("t5_ready", {31'h0, in_ready}, 32'h1);
            if (i >= 2 && i <= 4) begin
                chk("t5_wr_en", {31'h0, wr_en}, 32'h1);
                chk("t5_addr", {29'h0, wr_addr}, 32'(i - 1));
                chk("t5_data", {16'h0, wr_data}, 32'(i - 1));
            end
            if (i == 5) chk("t5_idle", {31'h0, wr_en}, 32'h0);
            @(posedge clk); #1;
        end

        // 6: reset right after a two-word MUL is accepted
        drive(OP_MUL, 32'h0005_0006, 3'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_wr_en", {31'h0, wr_en}, 32'h0);
        chk("t6_busy", {31'h0, busy}, 32'h0);
        chk("t6_addr", {29'h0, wr_addr}, 32'h0);
        chk("t6_data", {16'h0, wr_data}, 32'h0);
        @(negedge clk);
        chk("t6_no_hi", {31'h0, wr_en}, 32'h0);
        @(posedge clk); #1;

        // Randomized traffic with occasional resets
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!in_valid || acc_seen) begin
                if ($urandom_range(0, 9) < 7) begin
                    sel = $urandom_range(0, 9);
                    op  = (sel < 4) ? OP_MUL : 3'($urandom_range(0, 7));
                    case ($urandom_range(0, 3))
                        0:       res = 32'h0;
                        1:       res = {16'h0, 16'($urandom)};
                        2:       res = $urandom;
                        default: res = {16'($urandom), 16'h0};
                    endcase
                    in_valid = 1'b1; in_opcode = op; in_result = res;
                    in_rd = 3'($urandom_range(0, 7));
                end else begin
                    in_valid = 1'b0;
                end
            end
            rst = ($urandom_range(0, 99) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        chk("drain", 32'(q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
